// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: turns committed exceptions, interrupts and mret into CSR update pulses and redirects.
// Event sampled at edge N produces a one-cycle take_trap/flush at N+1; new requests are accepted again from edge N+2.
module trap_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_commit_valid,
    input  logic [31:0] i_commit_pc,
    input  logic [31:0] i_commit_next_pc,
    input  logic        i_exc_valid,
    input  logic [3:0]  i_exc_code,
    input  logic [31:0] i_exc_tval,
    input  logic        i_mret,
    input  logic        i_lsu_busy,
    input  logic        i_irq_ext,
    input  logic        i_irq_sw,
    input  logic        i_irq_timer,
    input  logic        i_mie_meie,
    input  logic        i_mie_msie,
    input  logic        i_mie_mtie,
    input  logic        i_mstatus_mie_cur,
    input  logic        i_mstatus_mpie_cur,
    input  logic [29:0] i_mtvec_base,
    input  logic [1:0]  i_mtvec_mode,
    input  logic [31:0] i_mepc_cur,
    output logic        o_take_trap,
    output logic        o_mcause_interrupt,
    output logic [30:0] o_mcause_exception_code,
    output logic [31:0] o_mepc_value,
    output logic [31:0] o_mtval_value,
    output logic        o_mstatus_mie,
    output logic        o_mstatus_mpie,
    output logic [1:0]  o_mstatus_mpp,
    output logic        o_flush,
    output logic [31:0] o_redirect_pc,
    output logic        o_irq_pending
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] TRAP = 2'd1;
    localparam logic [1:0] MRET = 2'd2;

    logic [1:0]  state;
    logic        shadow_intr;
    logic [30:0] shadow_code;
    logic [31:0] shadow_tval;

    logic        irq_ext_en;
    logic        irq_sw_en;
    logic        irq_timer_en;
    logic        irq_any;
    logic [3:0]  irq_code;
    logic        take_exc;
    logic        take_mret;
    logic        take_irq;
    logic [31:0] trap_base;
    logic [31:0] vec_target;

    assign irq_ext_en   = i_irq_ext & i_mie_meie;
    assign irq_sw_en    = i_irq_sw & i_mie_msie;
    assign irq_timer_en = i_irq_timer & i_mie_mtie;
    assign irq_any      = irq_ext_en | irq_sw_en | irq_timer_en;

    // Fixed source priority: external, then software, then timer.
    always_comb begin
        irq_code = 4'd7;
        if (irq_ext_en)
            irq_code = 4'd11;
        else if (irq_sw_en)
            irq_code = 4'd3;
    end

    assign take_exc  = i_commit_valid & i_exc_valid;
    assign take_mret = i_commit_valid & ~i_exc_valid & i_mret;
    assign take_irq  = i_commit_valid & ~i_exc_valid & ~i_mret & irq_any
                       & i_mstatus_mie_cur & ~i_lsu_busy;

    assign trap_base  = {i_mtvec_base, 2'b00};
    assign vec_target = trap_base + {26'd0, irq_code, 2'b00};

    assign o_take_trap = (state != IDLE);
    assign o_flush     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state                   <= IDLE;
            shadow_intr             <= 1'b0;
            shadow_code             <= 31'd0;
            shadow_tval             <= 32'd0;
            o_mcause_interrupt      <= 1'b0;
            o_mcause_exception_code <= 31'd0;
            o_mepc_value            <= 32'd0;
            o_mtval_value           <= 32'd0;
            o_mstatus_mie           <= 1'b0;
            o_mstatus_mpie          <= 1'b0;
            o_mstatus_mpp           <= 2'b00;
            o_redirect_pc           <= 32'd0;
            o_irq_pending           <= 1'b0;
        end else begin
            o_irq_pending <= irq_any;
            case (state)
                IDLE: begin
                    if (take_exc) begin
                        state                   <= TRAP;
                        shadow_intr             <= 1'b0;
                        shadow_code             <= {27'd0, i_exc_code};
                        shadow_tval             <= i_exc_tval;
                        o_mcause_interrupt      <= 1'b0;
                        o_mcause_exception_code <= {27'd0, i_exc_code};
                        o_mepc_value            <= i_commit_pc;
                        o_mtval_value           <= i_exc_tval;
                        o_mstatus_mie           <= 1'b0;
                        o_mstatus_mpie          <= i_mstatus_mie_cur;
                        o_mstatus_mpp           <= 2'b11;
                        o_redirect_pc           <= trap_base;
                    end else if (take_mret) begin
                        // Re-drive the last trap's cause/tval so the CSR write leaves them as the trap set them.
                        state                   <= MRET;
                        o_mcause_interrupt      <= shadow_intr;
                        o_mcause_exception_code <= shadow_code;
                        o_mepc_value            <= i_mepc_cur;
                        o_mtval_value           <= shadow_tval;
                        o_mstatus_mie           <= i_mstatus_mpie_cur;
                        o_mstatus_mpie          <= 1'b1;
                        o_mstatus_mpp           <= 2'b11;
                        o_redirect_pc           <= i_mepc_cur & ~32'h3;
                    end else if (take_irq) begin
                        state                   <= TRAP;
                        shadow_intr             <= 1'b1;
                        shadow_code             <= {27'd0, irq_code};
                        shadow_tval             <= 32'd0;
                        o_mcause_interrupt      <= 1'b1;
                        o_mcause_exception_code <= {27'd0, irq_code};
                        o_mepc_value            <= i_commit_next_pc;
                        o_mtval_value           <= 32'd0;
                        o_mstatus_mie           <= 1'b0;
                        o_mstatus_mpie          <= i_mstatus_mie_cur;
                        o_mstatus_mpp           <= 2'b11;
                        o_redirect_pc           <= (i_mtvec_mode == 2'd1) ? vec_target : trap_base;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: stimulus queues expected pulses, a negedge monitor pops and compares them.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_commit_valid;
    logic [31:0] i_commit_pc;
    logic [31:0] i_commit_next_pc;
    logic        i_exc_valid;
    logic [3:0]  i_exc_code;
    logic [31:0] i_exc_tval;
    logic        i_mret;
    logic        i_lsu_busy;
    logic        i_irq_ext, i_irq_sw, i_irq_timer;
    logic        i_mie_meie, i_mie_msie, i_mie_mtie;
    logic        i_mstatus_mie_cur, i_mstatus_mpie_cur;
    logic [29:0] i_mtvec_base;
    logic [1:0]  i_mtvec_mode;
    logic [31:0] i_mepc_cur;
    logic        o_take_trap;
    logic        o_mcause_interrupt;
    logic [30:0] o_mcause_exception_code;
    logic [31:0] o_mepc_value;
    logic [31:0] o_mtval_value;
    logic        o_mstatus_mie, o_mstatus_mpie;
    logic [1:0]  o_mstatus_mpp;
    logic        o_flush;
    logic [31:0] o_redirect_pc;
    logic        o_irq_pending;

    trap_ctrl dut (
        .clk(clk), .rst(rst),
        .i_commit_valid(i_commit_valid), .i_commit_pc(i_commit_pc),
        .i_commit_next_pc(i_commit_next_pc), .i_exc_valid(i_exc_valid),
        .i_exc_code(i_exc_code), .i_exc_tval(i_exc_tval), .i_mret(i_mret),
        .i_lsu_busy(i_lsu_busy), .i_irq_ext(i_irq_ext), .i_irq_sw(i_irq_sw),
        .i_irq_timer(i_irq_timer), .i_mie_meie(i_mie_meie), .i_mie_msie(i_mie_msie),
        .i_mie_mtie(i_mie_mtie), .i_mstatus_mie_cur(i_mstatus_mie_cur),
        .i_mstatus_mpie_cur(i_mstatus_mpie_cur), .i_mtvec_base(i_mtvec_base),
        .i_mtvec_mode(i_mtvec_mode), .i_mepc_cur(i_mepc_cur),
        .o_take_trap(o_take_trap), .o_mcause_interrupt(o_mcause_interrupt),
        .o_mcause_exception_code(o_mcause_exception_code), .o_mepc_value(o_mepc_value),
        .o_mtval_value(o_mtval_value), .o_mstatus_mie(o_mstatus_mie),
        .o_mstatus_mpie(o_mstatus_mpie), .o_mstatus_mpp(o_mstatus_mpp),
        .o_flush(o_flush), .o_redirect_pc(o_redirect_pc), .o_irq_pending(o_irq_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        intr;
        logic [30:0] code;
        logic [31:0] mepc;
        logic [31:0] mtval;
        logic        mie;
        logic        mpie;
        logic [1:0]  mpp;
        logic [31:0] redirect;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic intr, input logic [30:0] code, input logic [31:0] mepc,
                        input logic [31:0] mtval, input logic mie, input logic mpie,
                        input logic [31:0] redirect);
        exp_t e;
        e.intr = intr; e.code = code; e.mepc = mepc; e.mtval = mtval;
        e.mie = mie; e.mpie = mpie; e.mpp = 2'b11; e.redirect = redirect;
        exp_q.push_back(e);
    endtask

    // Every pulse must match a queued expectation; a stray or stretched pulse finds the queue empty.
    always @(negedge clk) begin
        if (!rst && o_take_trap) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 64'(o_take_trap), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("flush", 64'(o_flush), 64'd1);
                check("mcause_intr", 64'(o_mcause_interrupt), 64'(e.intr));
                check("mcause_code", 64'(o_mcause_exception_code), 64'(e.code));
                check("mepc", 64'(o_mepc_value), 64'(e.mepc));
                check("mtval", 64'(o_mtval_value), 64'(e.mtval));
                check("mstatus", 64'({o_mstatus_mie, o_mstatus_mpie, o_mstatus_mpp}),
                      64'({e.mie, e.mpie, e.mpp}));
                check("redirect", 64'(o_redirect_pc), 64'(e.redirect));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_take"}, 64'(o_take_trap), 64'd0);
        check({tag, "_flush"}, 64'(o_flush), 64'd0);
        check({tag, "_cause"}, 64'({o_mcause_interrupt, o_mcause_exception_code}), 64'd0);
        check({tag, "_mepc_mtval"}, {o_mepc_value, o_mtval_value}, 64'd0);
        check({tag, "_mstatus"}, 64'({o_mstatus_mie, o_mstatus_mpie, o_mstatus_mpp}), 64'd0);
        check({tag, "_redirect"}, 64'(o_redirect_pc), 64'd0);
        check({tag, "_irq_pending"}, 64'(o_irq_pending), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        i_commit_valid = 0; i_commit_pc = 0; i_commit_next_pc = 0;
        i_exc_valid = 0; i_exc_code = 0; i_exc_tval = 0; i_mret = 0; i_lsu_busy = 0;
        i_irq_ext = 0; i_irq_sw = 0; i_irq_timer = 0;
        i_mie_meie = 0; i_mie_msie = 0; i_mie_mtie = 0;
        i_mstatus_mie_cur = 1; i_mstatus_mpie_cur = 0;
        i_mtvec_base = 30'h80; i_mtvec_mode = 2'd0; i_mepc_cur = 0;
        cyc(); cyc();
        check_all_zero("reset");
        rst = 1'b0;
        cyc();

        // Illegal instruction exception, direct mtvec.
        push(1'b0, 31'd2, 32'h100, 32'hDEADBEEF, 1'b0, 1'b1, 32'h200);
        i_commit_valid = 1; i_commit_pc = 32'h100; i_commit_next_pc = 32'h104;
        i_exc_valid = 1; i_exc_code = 4'd2; i_exc_tval = 32'hDEADBEEF;
        cyc();
        i_commit_valid = 0; i_exc_valid = 0;
        cyc();
        check("pulse_one_cycle", 64'(o_take_trap), 64'd0);
        check("hold_mepc", 64'(o_mepc_value), 64'h100);

        // Vectored timer interrupt; no commit at first, so only pending shows.
        i_mtvec_mode = 2'd1; i_mie_mtie = 1; i_irq_timer = 1;
        cyc();
        check("irq_pending", 64'(o_irq_pending), 64'd1);
        push(1'b1, 31'd7, 32'h44, 32'd0, 1'b0, 1'b1, 32'h21C);
        i_commit_valid = 1; i_commit_pc = 32'h40; i_commit_next_pc = 32'h44;
        cyc();
        i_commit_valid = 0;
        cyc(); cyc();

        // Deferred while the LSU is busy, taken on the first commit after it drops.
        i_lsu_busy = 1; i_commit_valid = 1; i_commit_pc = 32'h5C; i_commit_next_pc = 32'h60;
        cyc(); cyc(); cyc();
        i_lsu_busy = 0;
        push(1'b1, 31'd7, 32'h60, 32'd0, 1'b0, 1'b1, 32'h21C);
        cyc();
        i_commit_valid = 0;
        cyc(); cyc();

        // Globally disabled: never taken.
        i_mstatus_mie_cur = 0; i_commit_valid = 1;
        for (int i = 0; i < 5; i++) begin
            i_lsu_busy = (i < 2);
            cyc();
        end
        i_commit_valid = 0; i_irq_timer = 0; i_mie_mtie = 0; i_mstatus_mie_cur = 1;
        cyc(); cyc();

        // ecall, then mret re-drives the ecall cause and tval.
        i_mtvec_mode = 2'd0;
        push(1'b0, 31'd11, 32'h200, 32'h12345678, 1'b0, 1'b1, 32'h200);
        i_commit_valid = 1; i_commit_pc = 32'h200; i_exc_valid = 1;
        i_exc_code = 4'd11; i_exc_tval = 32'h12345678;
        cyc();
        i_commit_valid = 0; i_exc_valid = 0;
        cyc(); cyc();
        push(1'b0, 31'd11, 32'h106, 32'h12345678, 1'b1, 1'b1, 32'h104);
        i_mstatus_mie_cur = 0; i_mstatus_mpie_cur = 1; i_mepc_cur = 32'h106;
        i_commit_valid = 1; i_mret = 1;
        cyc();
        i_commit_valid = 0; i_mret = 0; i_mstatus_mie_cur = 1;
        cyc(); cyc();

        // Exception collides with ext irq and mret; next-cycle commit is ignored.
        i_mtvec_mode = 2'd1; i_irq_ext = 1; i_mie_meie = 1;
        push(1'b0, 31'd11, 32'h300, 32'hAA, 1'b0, 1'b1, 32'h200);
        i_commit_valid = 1; i_commit_pc = 32'h300; i_exc_valid = 1;
        i_exc_code = 4'd11; i_exc_tval = 32'hAA; i_mret = 1;
        cyc();
        i_mret = 0; i_exc_code = 4'd3; i_commit_pc = 32'h304; i_exc_tval = 32'hBB;
        cyc();
        i_commit_valid = 0; i_exc_valid = 0; i_irq_ext = 0; i_mie_meie = 0;
        cyc(); cyc();

        // Reset asserted during the TRAP cycle.
        i_mtvec_mode = 2'd0;
        push(1'b0, 31'd4, 32'h400, 32'h403, 1'b0, 1'b1, 32'h200);
        i_commit_valid = 1; i_commit_pc = 32'h400; i_exc_valid = 1;
        i_exc_code = 4'd4; i_exc_tval = 32'h403;
        cyc();
        i_commit_valid = 0; i_exc_valid = 0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        cyc();
        check_all_zero("mid_reset");
        rst = 1'b0;
        cyc();
        check("after_reset_take", 64'(o_take_trap), 64'd0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap controller. It sits between the commit stage and the CSR file. It turns committed exceptions, pending interrupts and `mret` into one-cycle CSR hardware-update pulses and PC redirects. Its outputs drive the CSR file's `take_trap`, `i_mcause_*`, `i_mepc_value`, `i_mtval_value` and `i_mstatus_*` inputs. It reads back `o_mtvec_*`, `o_mepc_value` and `o_mstatus_*` from the CSR file.

## Interface
- No parameters; XLEN fixed at 32.
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset.
- `i_commit_valid`  in  1  an instruction is at the commit point this cycle.
- `i_commit_pc`  in  32  PC of that instruction.
- `i_commit_next_pc`  in  32  architectural next PC of that instruction.
- `i_exc_valid`  in  1  the committing instruction raised an exception (only meaningful with `i_commit_valid`).
- `i_exc_code`  in  4  exception code: 0 instr-misaligned, 2 illegal, 3 ebreak, 4 load-misaligned, 6 store-misaligned, 11 ecall.
- `i_exc_tval`  in  32  faulting address or instruction bits.
- `i_mret`  in  1  the committing instruction is `mret`.
- `i_lsu_busy`  in  1  a data-bus transaction is outstanding.
- `i_irq_ext` / `i_irq_sw` / `i_irq_timer`  in  1 each  level interrupt lines.
- `i_mie_meie` / `i_mie_msie` / `i_mie_mtie`  in  1 each  per-source enables.
- `i_mstatus_mie_cur`, `i_mstatus_mpie_cur`  in  1 each  current mstatus bits from the CSR file.
- `i_mtvec_base`  in  30  from the CSR file.
- `i_mtvec_mode`  in  2  from the CSR file.
- `i_mepc_cur`  in  32  from the CSR file.
- `o_take_trap`  out  1  CSR hardware write-enable pulse.
- `o_mcause_interrupt`  out  1  to the CSR file.
- `o_mcause_exception_code`  out  31  to the CSR file.
- `o_mepc_value`  out  32  to the CSR file.
- `o_mtval_value`  out  32  to the CSR file.
- `o_mstatus_mie` / `o_mstatus_mpie`  out  1 each  to the CSR file.
- `o_mstatus_mpp`  out  2  to the CSR file.
- `o_flush`  out  1  kill all younger instructions and redirect fetch.
- `o_redirect_pc`  out  32  fetch target; valid when `o_flush` is high.
- `o_irq_pending`  out  1  registered `|(irq & enable)`, for debug and WFI.

## Operation
- **State machine.** States are IDLE, TRAP and MRET. A request is accepted only in IDLE.
- **Event priority in IDLE** (evaluated when `i_commit_valid`=1):
  1. `i_exc_valid` → TRAP, as an exception.
  2. `i_mret` → MRET.
  3. An enabled interrupt with `i_mstatus_mie_cur`=1 and `i_lsu_busy`=0 → TRAP, as an interrupt.
  4. Otherwise stay in IDLE.
- **Interrupt source priority:** ext (code 11) > sw (code 3) > timer (code 7).
- **Interrupt gating:**
  - Interrupts are taken only when `i_commit_valid` is high, so the trap lands on an instruction boundary.
  - While `i_lsu_busy` is high, interrupts are deferred; they are not dropped, because the lines are level-sensitive.
- **Registered on entry to TRAP:**
  - Exception: cause = {0, zero-extended `i_exc_code`}, mepc = `i_commit_pc`, mtval = `i_exc_tval`.
  - Interrupt: cause = {1, code}, mepc = `i_commit_next_pc`, mtval = 0.
  - mstatus: mpie ← `i_mstatus_mie_cur`, mie ← 0, mpp ← 2'b11.
- **Redirect target in TRAP:**
  - If `i_mtvec_mode`==1 and the trap is an interrupt: {`i_mtvec_base`, 2'b00} + 4·code.
  - Otherwise: {`i_mtvec_base`, 2'b00}.
  - The sum wraps modulo 2^32.
- **Registered on entry to MRET:**
  - mstatus: mie ← `i_mstatus_mpie_cur`, mpie ← 1, mpp ← 2'b11.
  - mcause and mtval are re-driven from internal shadow registers holding the last trap's values. mepc is re-driven from `i_mepc_cur`.
  - Consequence: the CSR file's write-enable rewrites those fields unchanged. Exception: a software write to mcause or mtval made after the last trap is reverted at `mret`.
  - Redirect target = `i_mepc_cur` & ~32'h3.
- **Leaving TRAP or MRET:** both states last exactly one cycle, then return to IDLE unconditionally.
- **Ignored inputs:** commit-side inputs seen while in TRAP or MRET are ignored. They belong to flushed instructions.

## Timing
- **Latency:** an event sampled at edge N makes `o_take_trap`=1 and `o_flush`=1 for exactly cycle N+1, together with `o_redirect_pc` and all CSR value outputs. The block is back in IDLE at N+2, and a new request can be accepted at edge N+2.
- **Output hold:** all CSR value outputs are registered. They hold their last values when `o_take_trap`=0.
- **Reset values:** state IDLE. All outputs are 0, including `o_mstatus_mpp`=2'b00 and `o_redirect_pc`=0. Cause and tval shadows are 0.
- **Reset mid-operation:** `rst` asserted during TRAP or MRET forces IDLE at the next edge. The pulse is cut short and no second pulse is produced.
- **Simultaneous events:**
  - Exception with an interrupt: the exception wins. The interrupt remains pending and is taken on a later commit once the handler re-enables mie.
  - Exception with `i_mret` on the same commit: treated as an exception.
- **`o_irq_pending`:** registered one cycle behind the interrupt lines, independent of state.

## Test plan
- **Illegal exception.** Commit at pc=0x100 with exc code 2, tval=0xDEADBEEF, mtvec=0x200 direct, mie_cur=1. Required one cycle later:
  - `o_take_trap`=1, mcause={0,2}, mepc=0x100, mtval=0xDEADBEEF.
  - mie=0, mpie=1, mpp=3.
  - redirect=0x200, one-cycle flush.
- **Vectored timer interrupt.** mtvec base=0x80 (address 0x200) with mode 1, mtie=1, irq_timer=1, commit with next_pc=0x44. Required: mcause={1,7}, mepc=0x44, mtval=0, redirect=0x21C.
- **Deferral.** Timer interrupt pending while `i_lsu_busy`=1 for 3 cycles. Required: no trap during those cycles; trap on the first commit after busy drops. Repeat with mie_cur=0: never taken.
- **mret.** mret with mepc_cur=0x106 and mpie_cur=1, after a trap with cause 11. Required:
  - mie=1, mpie=1, mcause re-driven as {0,11}.
  - redirect=0x104.
- **Collision.** Exception code 11 and ext irq in the same commit. Required: cause 11 with interrupt bit 0. A commit in the cycle that follows is ignored (no second pulse).
- **Reset.** `rst` asserted in the TRAP cycle. Required: all outputs 0 on the next cycle and the state machine in IDLE.
